// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Widest register address the shadow entries can hold (AW must not exceed it).
    localparam int PIPE_AW_MAX = 8;

    typedef logic [PIPE_AW_MAX-1:0] pipe_addr_t;

    typedef struct packed {
        logic       valid;
        pipe_addr_t rd;
        pipe_addr_t rs;
        pipe_addr_t rt;
        logic       rs_used;
        logic       rt_used;
        logic       regwrite;
        logic       memread;
    } pipe_shadow_t;

    localparam pipe_addr_t ZERO_REG = '0;
    localparam int         FWD_RF   = 0;

    // True when the entry is a live instruction that will write register r.
    function automatic logic shadow_writes(input pipe_shadow_t e, input pipe_addr_t r);
        return e.valid & e.regwrite & (e.rd == r) & (r != ZERO_REG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_fwd_sel
//  Description : Youngest-producer priority match of one source register.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic                           src_used,
    input  pipe_addr_t                     src,
    input  pipe_shadow_t [FWD_STAGES-1:0]  stages,   // index k-1 holds stage k
    output logic [SELW-1:0]                sel
);

    logic w_unused_fields;
    assign w_unused_fields = ^stages;

    // Scan oldest to youngest so the youngest matching stage is the final winner.
    always_comb begin
        sel = SELW'(FWD_RF);
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (src_used && shadow_writes(stages[k-1], src)) begin
                sel = SELW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_unit
//  Description : Load-use stall, EX forwarding selects and bubble/flush control.
//                Optional PIPE_HAZ_STATS_EN adds stall/flush cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int AW         = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_flush,
    output logic            stall,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_bubble,
    output logic [SELW-1:0] fwd_a_sel,
    output logic [SELW-1:0] fwd_b_sel
`ifdef PIPE_HAZ_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    pipe_shadow_t [FWD_STAGES:0] r_sh;
    pipe_shadow_t                w_ex_next;
    pipe_addr_t                  w_id_rs;
    pipe_addr_t                  w_id_rt;
    logic                        w_load_use;
    logic                        w_unused_ex;

    assign w_id_rs     = pipe_addr_t'(id_rs);
    assign w_id_rt     = pipe_addr_t'(id_rt);
    assign w_unused_ex = ^r_sh[0];

    // A load still younger than its forwardable stage blocks its consumer in ID.
    always_comb begin
        w_load_use = 1'b0;
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (r_sh[j].memread &&
                ((id_rs_used && shadow_writes(r_sh[j], w_id_rs)) ||
                 (id_rt_used && shadow_writes(r_sh[j], w_id_rt)))) begin
                w_load_use = 1'b1;
            end
        end
    end

    assign stall        = id_valid & ~ex_flush & w_load_use;
    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign if_id_flush  = ex_flush;
    assign id_ex_bubble = stall | ex_flush | ~id_valid;

    always_comb begin
        w_ex_next = '0;
        if (!id_ex_bubble) begin
            w_ex_next.valid    = 1'b1;
            w_ex_next.rd       = pipe_addr_t'(id_rd);
            w_ex_next.rs       = w_id_rs;
            w_ex_next.rt       = w_id_rt;
            w_ex_next.rs_used  = id_rs_used;
            w_ex_next.rt_used  = id_rt_used;
            w_ex_next.regwrite = id_regwrite;
            w_ex_next.memread  = id_memread;
        end
    end

    // Post-EX stages never stall, so the shadow shifts every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[FWD_STAGES-1:0], w_ex_next};
        end
    end

    pipe_fwd_sel #(
        .FWD_STAGES (FWD_STAGES),
        .SELW       (SELW)
    ) u_fwd_a (
        .src_used (r_sh[0].rs_used),
        .src      (r_sh[0].rs),
        .stages   (r_sh[FWD_STAGES:1]),
        .sel      (fwd_a_sel)
    );

    pipe_fwd_sel #(
        .FWD_STAGES (FWD_STAGES),
        .SELW       (SELW)
    ) u_fwd_b (
        .src_used (r_sh[0].rt_used),
        .src      (r_sh[0].rt),
        .stages   (r_sh[FWD_STAGES:1]),
        .sel      (fwd_b_sel)
    );

`ifdef PIPE_HAZ_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (ex_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_unit
//  Description : Bench for two pipe_hazard_unit configurations (2/1 and 3/2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, ex_flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       a_stall, a_pc_write, a_if_id_write, a_if_id_flush, a_bubble;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic       b_stall, b_pc_write, b_if_id_write, b_if_id_flush, b_bubble;
    logic [1:0] b_fwd_a, b_fwd_b;
`ifdef PIPE_HAZ_STATS_EN
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .stall(a_stall), .pc_write(a_pc_write), .if_id_write(a_if_id_write),
        .if_id_flush(a_if_id_flush), .id_ex_bubble(a_bubble),
        .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b)
`ifdef PIPE_HAZ_STATS_EN
        , .stall_cycles(a_sc), .flush_count(a_fc)
`endif
    );

    pipe_hazard_unit #(.AW(5), .FWD_STAGES(3), .LOAD_LAT(2)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .stall(b_stall), .pc_write(b_pc_write), .if_id_write(b_if_id_write),
        .if_id_flush(b_if_id_flush), .id_ex_bubble(b_bubble),
        .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b)
`ifdef PIPE_HAZ_STATS_EN
        , .stall_cycles(b_sc), .flush_count(b_fc)
`endif
    );

    // ---------------- reference model: queue of in-flight instructions by age
    typedef struct {
        bit v;
        int rd, rs, rt;
        bit rsu, rtu, rw, mr;
    } ins_t;

    ins_t hist0[$];
    ins_t hist1[$];
    int   m_sc[2];
    int   m_fc;

    function automatic int nf(int c); return (c != 0) ? 3 : 2; endfunction
    function automatic int nl(int c); return (c != 0) ? 2 : 1; endfunction

    function automatic ins_t ent(int c, int k);
        return (c != 0) ? hist1[k] : hist0[k];
    endfunction

    function automatic bit writes(int c, int k, int r);
        ins_t e;
        e = ent(c, k);
        return e.v && e.rw && (e.rd == r) && (r != 0);
    endfunction

    // A load younger than age LOAD_LAT+1 cannot yet supply its data.
    function automatic bit m_stall(int c);
        bit hz;
        hz = 0;
        for (int j = 0; j < nl(c); j++) begin
            if (ent(c, j).mr &&
                ((id_rs_used && writes(c, j, int'(id_rs))) ||
                 (id_rt_used && writes(c, j, int'(id_rt)))))
                hz = 1;
        end
        return id_valid && !ex_flush && hz;
    endfunction

    function automatic int m_sel(int c, bit opb);
        ins_t ex;
        int   r;
        ex = ent(c, 0);
        r  = opb ? ex.rt : ex.rs;
        if (!(opb ? ex.rtu : ex.rsu)) return 0;
        for (int k = 1; k <= nf(c); k++)
            if (writes(c, k, r)) return k;
        return 0;
    endfunction

    function automatic logic [8:0] m_vec(int c);
        bit s;
        s = m_stall(c);
        return {s, !s, !s, ex_flush, s || ex_flush || !id_valid,
                2'(m_sel(c, 1'b0)), 2'(m_sel(c, 1'b1))};
    endfunction

    function automatic logic [8:0] o_vec(int c);
        if (c != 0) return {b_stall, b_pc_write, b_if_id_write, b_if_id_flush, b_bubble, b_fwd_a, b_fwd_b};
        return {a_stall, a_pc_write, a_if_id_write, a_if_id_flush, a_bubble, a_fwd_a, a_fwd_b};
    endfunction

    // Advance the model by one clock edge, then move to edge+1.
    task automatic tick();
        ins_t n, z;
        bit   s[2];
        s[0] = m_stall(0);
        s[1] = m_stall(1);
        z.v = 0; z.rd = 0; z.rs = 0; z.rt = 0; z.rsu = 0; z.rtu = 0; z.rw = 0; z.mr = 0;
        n.v = 1; n.rd = int'(id_rd); n.rs = int'(id_rs); n.rt = int'(id_rt);
        n.rsu = id_rs_used; n.rtu = id_rt_used; n.rw = id_regwrite; n.mr = id_memread;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_sc[c] = 0;
                if (c == 0) begin hist0.delete(); for (int k = 0; k <= nf(0); k++) hist0.push_back(z); end
                else        begin hist1.delete(); for (int k = 0; k <= nf(1); k++) hist1.push_back(z); end
            end else begin
                if (s[c]) m_sc[c]++;
                if (c == 0) begin
                    hist0.push_front((s[0] || ex_flush || !id_valid) ? z : n);
                    void'(hist0.pop_back());
                end else begin
                    hist1.push_front((s[1] || ex_flush || !id_valid) ? z : n);
                    void'(hist1.pop_back());
                end
            end
        end
        if (rst) m_fc = 0; else if (ex_flush) m_fc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, int rs, bit rsu, int rt, bit rtu, int rd, bit rw, bit mr, bit fl);
        id_valid = v; id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
        id_rd = 5'(rd); id_regwrite = rw; id_memread = mr; ex_flush = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        rst = 1'b1;
        nop();
        tick();
        tick();
        #5;
        checks++;
        if (o_vec(0) !== 9'b0_1_1_0_1_00_00) begin
            errors++; $display("FAIL reset_outputs_a got %b want %b", o_vec(0), 9'b011010000);
        end
        checks++;
        if (o_vec(1) !== 9'b0_1_1_0_1_00_00) begin
            errors++; $display("FAIL reset_outputs_b got %b want %b", o_vec(1), 9'b011010000);
        end
        ex_flush = 1'b1;
        #1;
        checks++;
        if ({a_if_id_flush, b_if_id_flush, a_bubble} !== 3'b111) begin
            errors++; $display("FAIL reset_flush_pass got %b want 111", {a_if_id_flush, b_if_id_flush, a_bubble});
        end
        ex_flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu_chain();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
        #5;
        checks++;
        if ({a_stall, b_stall} !== 2'b00) begin
            errors++; $display("FAIL alu_no_stall got %b want 00", {a_stall, b_stall});
        end
        tick();
        nop();
        #5;
        checks++;
        if ({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b} !== 8'b01_01_01_01) begin
            errors++; $display("FAIL alu_fwd got %b want 01010101", {a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b});
        end
        tick();
    endtask

    task automatic test_load_use();
        int sa, sb;
        sa = 0; sb = 0;
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #5;
            sa += int'(a_stall);
            sb += int'(b_stall);
            if (i == 0) begin
                checks++;
                if ({a_bubble, a_pc_write, a_if_id_write} !== 3'b100) begin
                    errors++; $display("FAIL lu_bubble got %b want 100", {a_bubble, a_pc_write, a_if_id_write});
                end
            end
            if (i == 2) begin
                checks++;
                if (a_fwd_a !== 2'd2) begin
                    errors++; $display("FAIL lu_fwd_a got %0d want 2", a_fwd_a);
                end
            end
            tick();
        end
        nop();
        #5;
        checks++;
        if (b_fwd_a !== 2'd3) begin
            errors++; $display("FAIL lu3_fwd_a got %0d want 3", b_fwd_a);
        end
        checks++;
        if (sa != 1 || sb != 2) begin
            errors++; $display("FAIL lu_stall_len got %0d/%0d want 1/2", sa, sb);
        end
        tick();
    endtask

    task automatic test_r0();
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0);
        tick();
        drive(1, 0, 1, 0, 1, 2, 1, 0, 0);
        #5;
        checks++;
        if ({a_stall, b_stall} !== 2'b00) begin
            errors++; $display("FAIL r0_stall got %b want 00", {a_stall, b_stall});
        end
        tick();
        nop();
        #5;
        checks++;
        if ({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b} !== 8'd0) begin
            errors++; $display("FAIL r0_fwd got %b want 0", {a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b});
        end
        tick();
    endtask

    task automatic test_double_producer();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 9, 1, 10, 1, 0, 0);
        tick();
        nop();
        #5;
        checks++;
        if ({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b} !== 8'b01_00_01_00) begin
            errors++; $display("FAIL dbl_prod got %b want 01000100", {a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b});
        end
        tick();
    endtask

    task automatic test_flush_reset();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 1);
        #5;
        checks++;
        if ({a_stall, a_bubble, a_if_id_flush, b_stall, b_bubble, b_if_id_flush} !== 6'b011_011) begin
            errors++; $display("FAIL flush_wins got %b want 011011",
                {a_stall, a_bubble, a_if_id_flush, b_stall, b_bubble, b_if_id_flush});
        end
        tick();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 0);
        tick();
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0);
        tick();
        drive(1, 7, 1, 0, 0, 9, 1, 0, 0);
        #5;
        checks++;
        if (a_fwd_a !== 2'd1) begin
            errors++; $display("FAIL pre_rst_fwd got %0d want 1", a_fwd_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nop();
        #5;
        checks++;
        if ({a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b} !== 8'd0) begin
            errors++; $display("FAIL post_rst_fwd got %b want 0", {a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b});
        end
        tick();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0);
        tick();
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
        #5;
        checks++;
        if ({a_stall, b_stall} !== 2'b11) begin
            errors++; $display("FAIL mid_stall got %b want 11", {a_stall, b_stall});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #5;
        checks++;
        if ({a_stall, b_stall} !== 2'b00) begin
            errors++; $display("FAIL rst_drops_stall got %b want 00", {a_stall, b_stall});
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 3));
            id_rs_used  = ($urandom_range(0, 3) != 0);
            id_rt_used  = ($urandom_range(0, 3) != 0);
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread  = ($urandom_range(0, 2) == 0);
            ex_flush    = ($urandom_range(0, 9) == 0);
            #5;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (o_vec(c) !== m_vec(c)) begin
                    errors++;
                    $display("FAIL random cfg%0d cycle %0d got %b want %b", c, i, o_vec(c), m_vec(c));
                end
            end
            tick();
        end
        rst = 1'b0;
        nop();
    endtask

`ifdef PIPE_HAZ_STATS_EN
    task automatic test_stats();
        #5;
        checks++;
        if (a_sc !== 32'(m_sc[0]) || b_sc !== 32'(m_sc[1])) begin
            errors++; $display("FAIL stall_cycles got %0d/%0d want %0d/%0d", a_sc, b_sc, m_sc[0], m_sc[1]);
        end
        checks++;
        if (a_fc !== 32'(m_fc) || b_fc !== 32'(m_fc)) begin
            errors++; $display("FAIL flush_count got %0d/%0d want %0d", a_fc, b_fc, m_fc);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        nop();
        m_sc[0] = 0; m_sc[1] = 0; m_fc = 0;
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_r0();
        test_double_producer();
        test_flush_reset();
        test_random();
`ifdef PIPE_HAZ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard-detection and forwarding controller for the in-order integer pipeline.
- Tracks the destination register of every in-flight instruction from EX to WB in an internal shadow shift register.
- Generates the load-use stall, per-operand forwarding selects for EX, and bubble/flush controls.
- Replaces the fixed 2-stage, 1-cycle-load-latency hazard/forwarding pair with one block configurable in register-address width, forwarding depth and load latency.

Parameters:
- AW, 5: register address width; register 0 is hard-wired zero and never forwarded or stalled on.
- FWD_STAGES, 2: number of post-EX stages that can forward (stage 1 = EX/MEM, stage FWD_STAGES = WB). Legal range 1..6.
- LOAD_LAT, 1: first stage index at which load data becomes forwardable, minus 1. Legal range 0..FWD_STAGES-1.
- SELW, $clog2(FWD_STAGES+1): forwarding select width (derived; do not override).

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- id_valid, input, 1: a real instruction is present in ID.
- id_rs, input, AW: ID source A.
- id_rt, input, AW: ID source B.
- id_rs_used, input, 1: ID instruction reads rs.
- id_rt_used, input, 1: ID instruction reads rt.
- id_rd, input, AW: ID destination.
- id_regwrite, input, 1: ID instruction writes id_rd.
- id_memread, input, 1: ID instruction is a load.
- ex_flush, input, 1: branch/jump resolved taken in EX; kill IF/ID contents.
- stall, output, 1: load-use hazard; hold PC and IF/ID.
- pc_write, output, 1: equals ~stall.
- if_id_write, output, 1: equals ~stall.
- if_id_flush, output, 1: equals ex_flush.
- id_ex_bubble, output, 1: insert NOP into ID/EX; equals stall | ex_flush | ~id_valid.
- fwd_a_sel, output, SELW: EX operand A source (0 = register file, k = stage k result).
- fwd_b_sel, output, SELW: same for operand B.

Behaviour:
- Shadow register sh[0..FWD_STAGES]: one entry per stage, each holding {valid, rd, rs, rt, rs_used, rt_used, regwrite, memread}. sh[0] = instruction currently in EX.
- Every cycle, sh[k] <= sh[k-1] for k >= 1; the shift never stops, because later stages never stall.
- sh[0] loads the ID fields when id_ex_bubble = 0; otherwise it loads a bubble (valid = 0, all other fields 0).
- Writer predicate W(k, r): sh[k].valid & sh[k].regwrite & sh[k].rd == r & r != 0.
- fwd_a_sel = smallest k in 1..FWD_STAGES with W(k, sh[0].rs) & sh[0].rs_used; 0 if no such k. Youngest producer wins.
- fwd_b_sel: same rule using rt.
- Both selects are combinational from registers only (no input-to-output path).
- Load-forwarding legality: a load at stage k is forwardable only if k >= LOAD_LAT+1. The stall rule below guarantees selects never point at an illegal load stage.
- stall = id_valid & ~ex_flush & OR over j in 0..LOAD_LAT-1 of (sh[j].memread & (W(j, id_rs) & id_rs_used | W(j, id_rt) & id_rt_used)).
- LOAD_LAT = 0: stall is constant 0.
- Stall length: a load immediately followed by its consumer stalls exactly LOAD_LAT cycles.
- ex_flush and stall together: flush wins; stall = 0, and the killed ID instruction becomes a bubble.
- Reset: all sh entries are invalid. Outputs during and after reset: stall = 0, pc_write = 1, if_id_write = 1, if_id_flush = ex_flush, id_ex_bubble = 1 while id_valid = 0, fwd_a_sel = fwd_b_sel = 0.
- rst asserted mid-stall: stall drops on the next cycle.
- Instruction leaving sh[FWD_STAGES]: no longer forwarded. The register file must provide write-before-read for the WB stage.

Optional Feature:
- Macro: PIPE_HAZ_STATS_EN.
- Defined: adds outputs stall_cycles (32) and flush_count (32), both saturating at 0xFFFFFFFF and cleared by rst.
  - stall_cycles increments on every cycle with stall = 1.
  - flush_count increments on every cycle with ex_flush = 1.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the sh-entry struct type (pipe_shadow_t);
  - the constant ZERO_REG = 0;
  - the select encoding constant FWD_RF = 0.
- One sub-module, pipe_fwd_sel: a priority match of one source register against sh[1..FWD_STAGES]. It is instantiated twice, once for A and once for B.

Test Plan:
- ALU chain, defaults: add r3 then sub r4,r3,r3 back-to-back -> fwd_a_sel = fwd_b_sel = 1 when sub is in EX; stall never asserts.
- Load-use, defaults: lw r5 then add r6,r5,r1 -> stall = 1 for exactly 1 cycle; one bubble in sh[0]; fwd_a_sel = 2 when add is in EX.
- LOAD_LAT = 2, FWD_STAGES = 3: lw r7 then its consumer -> stall for 2 cycles; fwd_a_sel = 3 when the consumer is in EX.
- r0 writes: lw r0 then add r2,r0,r0 -> no stall; both selects = 0.
- Double producer: add r3 at stage 2 and add r3 at stage 1, consumer in EX -> fwd_a_sel = 1.
- Load-use coinciding with ex_flush = 1 -> stall = 0, id_ex_bubble = 1, if_id_flush = 1. Then assert rst for 1 cycle -> all shadow entries invalid and selects = 0 on the next cycle.
